// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int         MEM_DEPTH_DEF = 32;
  localparam int         PC_W          = $clog2(MEM_DEPTH_DEF);
  localparam int         RS_DEPTH_DEF  = 4;
  localparam logic [3:0] OPC_HALT      = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPT,
    VALID,
    HALTED
  } fetch_state_e;

endpackage

// File: rtl/fetch_ret_stack.sv
// Return-address LIFO for call/return redirects; overflowing pushes are dropped, popping empty reads 0.
module fetch_ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         full,
  output logic         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] wr_idx, top_idx;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign wr_idx  = IW'(cnt_q);
  assign top_idx = IW'(cnt_q - CW'(1));
  assign top_data = empty ? '0 : mem_q[top_idx];

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (pop) begin
      if (!empty) cnt_d = cnt_q - CW'(1);
    end else if (push && !full) begin
      mem_d[wr_idx] = push_data;
      cnt_d         = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: PC ownership, imem read, valid/ready presentation, redirects and halt.
// Build option FETCH_RET_STACK_EN adds a call/return stack; without it call acts as a jump and ret is ignored.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int         MEM_DEPTH   = MEM_DEPTH_DEF,
  parameter logic [3:0] HALT_OPCODE = OPC_HALT
`ifdef FETCH_RET_STACK_EN
  , parameter int       RS_DEPTH    = RS_DEPTH_DEF
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] pc_start,
  output logic [15:0] imem_pc,
  output logic        imem_en,
  input  logic [15:0] imem_instr,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redir_req,
  input  logic [15:0] redir_target,
  input  logic        call_req,
  input  logic        ret_req,
  output logic        halted,
  output logic        rs_err
);

  localparam int PW = $clog2(MEM_DEPTH);

  // Handshake: a word transfers on a cycle where instr_valid & instr_ready are both high and no
  // redirect is taken; instr_valid never drops and instr_out never changes before that, except on flush.
  fetch_state_e  state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [PW-1:0] instr_pc_q, instr_pc_d;
  logic [15:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          active;
  logic          redir_take;
  logic [PW-1:0] redir_pc;
  logic          unused_hi;

  assign active    = (state_q == FETCH) || (state_q == CAPT) || (state_q == VALID);
  assign unused_hi = ^{redir_target[15:PW], pc_start[15:PW]};

`ifdef FETCH_RET_STACK_EN
  logic          rs_push, rs_pop, rs_full, rs_empty;
  logic [PW-1:0] rs_top, ret_addr;
  logic          rs_err_q, rs_err_d;

  assign ret_addr = instr_pc_q + PW'(1);
  assign rs_pop   = active & ret_req;
  assign rs_push  = active & call_req & ~ret_req;

  fetch_ret_stack #(.DEPTH(RS_DEPTH), .W(PW)) u_ret_stack (
    .clk       (clk),
    .rst       (reset),
    .push      (rs_push),
    .pop       (rs_pop),
    .push_data (ret_addr),
    .top_data  (rs_top),
    .full      (rs_full),
    .empty     (rs_empty)
  );

  // ret outranks call, which outranks a plain jump; call and jump share redir_target
  assign redir_take = active & (ret_req | call_req | redir_req);
  assign redir_pc   = ret_req ? rs_top : redir_target[PW-1:0];
  assign rs_err_d   = rs_err_q | (rs_push & rs_full) | (rs_pop & rs_empty);
  assign rs_err     = rs_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rs_err_q <= 1'b0;
    else       rs_err_q <= rs_err_d;
  end
`else
  logic unused_ret;

  assign unused_ret = ret_req;
  assign redir_take = active & (call_req | redir_req);
  assign redir_pc   = redir_target[PW-1:0];
  assign rs_err     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    if (redir_take) begin
      valid_d = 1'b0;
      pc_d    = redir_pc;
      state_d = FETCH;
    end else begin
      case (state_q)
        IDLE, HALTED: begin
          if (start) begin
            pc_d    = pc_start[PW-1:0];
            state_d = FETCH;
          end
        end
        FETCH: state_d = CAPT;
        CAPT: begin
          instr_d    = imem_instr;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = VALID;
        end
        VALID: begin
          if (instr_ready) begin
            valid_d = 1'b0;
            if (instr_q[15:12] == HALT_OPCODE) begin
              state_d = HALTED;
            end else begin
              pc_d    = pc_q + PW'(1);
              state_d = FETCH;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_en     = (state_q == FETCH);
  assign imem_pc     = imem_en ? 16'(pc_q) : 16'd0;
  assign instr_out   = instr_q;
  assign instr_pc    = 16'(instr_pc_q);
  assign instr_valid = valid_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: synchronous imem model, table of start addresses, scoreboard of handshaken words.
module tb_fetch_ctrl;

`ifdef FETCH_RET_STACK_EN
  localparam bit RS_EN = 1'b1;
`else
  localparam bit RS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pc_start = '0;
  logic [15:0] imem_pc;
  logic        imem_en;
  logic [15:0] imem_instr = '0;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        redir_req = 1'b0;
  logic [15:0] redir_target = '0;
  logic        call_req = 1'b0;
  logic        ret_req = 1'b0;
  logic        halted;
  logic        rs_err;

  fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pc_start     (pc_start),
    .imem_pc      (imem_pc),
    .imem_en      (imem_en),
    .imem_instr   (imem_instr),
    .instr_out    (instr_out),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .redir_req    (redir_req),
    .redir_target (redir_target),
    .call_req     (call_req),
    .ret_req      (ret_req),
    .halted       (halted),
    .rs_err       (rs_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  // synchronous-read instruction memory
  logic [15:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i * 37);
  always @(posedge clk) if (imem_en) imem_instr <= mem[imem_pc[4:0]];

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int hs_cyc[$];
  int hs_cnt = 0;
  int en_cnt = 0;
  logic prev_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic redir_now();
    return redir_req | call_req | (RS_EN & ret_req);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (imem_en) begin
        check("imem_en_pulse", 64'(prev_en), 0);
        en_cnt++;
      end
      prev_en = imem_en;
      if (instr_valid && instr_ready && !redir_now()) begin
        hs_cyc.push_back(cyc);
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected", {1'b1, instr_pc, instr_out}, 0);
        end else begin
          check("sb_instr", {instr_pc, instr_out}, exp_q.pop_front());
        end
      end
    end else begin
      prev_en = 1'b0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int addr);
    exp_q.push_back({16'(addr), mem[addr]});
  endtask

  task automatic pulse_start(input logic [15:0] addr);
    pc_start = addr;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (hs_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("hs_timeout", 64'(hs_cnt >= target), 1);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!instr_valid && n < budget) begin
      tick();
      n++;
    end
    check("valid_timeout", 64'(instr_valid), 1);
  endtask

  task automatic apply_reset();
    int en0;
    reset = 1'b1;
    start = 1'b0;
    redir_req = 1'b0;
    call_req = 1'b0;
    ret_req = 1'b0;
    #2;
    check("reset_outputs", {imem_en, imem_pc, instr_out, instr_pc, instr_valid, halted, rs_err}, 0);
    exp_q.delete();
    hs_cyc.delete();
    tick();
    tick();
    reset = 1'b0;
    en0 = en_cnt;
    repeat (3) tick();
    check("idle_no_fetch", 64'(en_cnt - en0), 0);
    check("idle_no_valid", 64'(instr_valid), 0);
  endtask

  typedef struct {
    logic [15:0] pc_start;
    logic [4:0]  e0;
    logic [4:0]  e1;
    logic [4:0]  e2;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int base, c0, en0;

    vecs[0] = '{16'h0000, 5'd0,  5'd1, 5'd2};
    vecs[1] = '{16'h001F, 5'd31, 5'd0, 5'd1};
    vecs[2] = '{16'h0005, 5'd5,  5'd6, 5'd7};
    vecs[3] = '{16'hFFE9, 5'd9,  5'd10, 5'd11};

    // start address table: sequence, wrap, upper-bit discard, 3-cycle cadence
    foreach (vecs[r]) begin
      apply_reset();
      instr_ready = 1'b1;
      push_exp(int'(vecs[r].e0));
      push_exp(int'(vecs[r].e1));
      push_exp(int'(vecs[r].e2));
      base = hs_cnt;
      en0 = en_cnt;
      c0 = cyc;
      pulse_start(vecs[r].pc_start);
      wait_hs(base + 3, 30);
      if (hs_cyc.size() >= 3) begin
        check("first_valid_latency", 64'(hs_cyc[0] - c0), 3);
        check("cadence", 64'(hs_cyc[2] - hs_cyc[0]), 6);
      end
      check("fetch_pulses", 64'(en_cnt - en0), 3);
      check("sb_drain", 64'(exp_q.size()), 0);
    end

    // decoder stall in VALID
    apply_reset();
    instr_ready = 1'b0;
    push_exp(0);
    pulse_start(16'd0);
    wait_valid(20);
    en0 = en_cnt;
    repeat (5) begin
      tick();
      check("stall_valid", 64'(instr_valid), 1);
      check("stall_instr", 64'(instr_out), 64'(mem[0]));
    end
    check("stall_no_fetch", 64'(en_cnt - en0), 0);
    push_exp(1);
    base = hs_cnt;
    instr_ready = 1'b1;
    wait_hs(base + 2, 20);
    check("sb_drain", 64'(exp_q.size()), 0);

    // jump during CAPT of address 2
    apply_reset();
    instr_ready = 1'b1;
    push_exp(0);
    push_exp(1);
    base = hs_cnt;
    pulse_start(16'd0);
    wait_hs(base + 2, 20);
    tick();
    redir_req = 1'b1;
    redir_target = 16'hFFE7;
    tick();
    redir_req = 1'b0;
    push_exp(7);
    push_exp(8);
    wait_hs(base + 4, 20);
    check("sb_drain", 64'(exp_q.size()), 0);

`ifdef FETCH_RET_STACK_EN
    // call from instr_pc 3 to 10, then return to 4
    apply_reset();
    instr_ready = 1'b1;
    push_exp(0);
    push_exp(1);
    push_exp(2);
    base = hs_cnt;
    pulse_start(16'd0);
    wait_hs(base + 3, 30);
    tick();
    tick();
    check("call_site_pc", 64'(instr_pc), 3);
    call_req = 1'b1;
    redir_target = 16'd10;
    tick();
    call_req = 1'b0;
    push_exp(10);
    wait_hs(base + 4, 20);
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    push_exp(4);
    push_exp(5);
    wait_hs(base + 6, 20);
    check("rs_err_clean", 64'(rs_err), 0);
    check("sb_drain", 64'(exp_q.size()), 0);

    // five nested calls overflow a four-deep stack
    apply_reset();
    instr_ready = 1'b0;
    pulse_start(16'd0);
    for (int i = 0; i < 4; i++) begin
      call_req = 1'b1;
      redir_target = 16'(12 + i);
      tick();
      call_req = 1'b0;
      tick();
    end
    check("rs_err_at_full", 64'(rs_err), 0);
    call_req = 1'b1;
    redir_target = 16'd20;
    tick();
    call_req = 1'b0;
    tick();
    check("rs_err_overflow", 64'(rs_err), 1);
    tick();
    check("rs_err_sticky", 64'(rs_err), 1);
`else
    // call behaves as a jump; ret is ignored without the return stack
    apply_reset();
    instr_ready = 1'b1;
    push_exp(0);
    push_exp(1);
    push_exp(2);
    base = hs_cnt;
    pulse_start(16'd0);
    wait_hs(base + 3, 30);
    tick();
    tick();
    call_req = 1'b1;
    redir_target = 16'd20;
    tick();
    call_req = 1'b0;
    push_exp(20);
    wait_hs(base + 4, 20);
    instr_ready = 1'b0;
    push_exp(21);
    wait_valid(20);
    ret_req = 1'b1;
    repeat (3) begin
      tick();
      check("ret_ignored_valid", 64'(instr_valid), 1);
      check("ret_ignored_pc", 64'(instr_pc), 21);
    end
    ret_req = 1'b0;
    instr_ready = 1'b1;
    wait_hs(base + 5, 20);
    check("rs_err_tied", 64'(rs_err), 0);
    check("sb_drain", 64'(exp_q.size()), 0);
`endif

    // halt word at address 4, redirect ignored while halted, restart
    mem[4] = 16'hF000;
    apply_reset();
    instr_ready = 1'b1;
    for (int a = 0; a < 5; a++) push_exp(a);
    base = hs_cnt;
    pulse_start(16'd0);
    wait_hs(base + 5, 40);
    check("halted_set", 64'(halted), 1);
    en0 = en_cnt;
    redir_req = 1'b1;
    redir_target = 16'd9;
    tick();
    redir_req = 1'b0;
    repeat (3) tick();
    check("halted_hold", 64'(halted), 1);
    check("halted_no_fetch", 64'(en_cnt - en0), 0);
    check("halted_no_valid", 64'(instr_valid), 0);
    push_exp(0);
    push_exp(1);
    pulse_start(16'd0);
    check("halted_clear", 64'(halted), 0);
    wait_hs(base + 7, 20);
    check("sb_drain", 64'(exp_q.size()), 0);
    mem[4] = 16'h1000 + 16'(4 * 37);

    apply_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
